// File: rtl/snn_infer_ctrl_pkg.sv
// rtl/snn_infer_ctrl_pkg.sv - shared types and helper functions for the SNN inference controller
package snn_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        RUN      = 3'd2,
        WAIT_NET = 3'd3,
        ARGMAX   = 3'd4,
        RESULT   = 3'd5
    } state_t;

    // Widest neuron count / counter the helpers handle; callers zero-extend into these slots.
    localparam int MAX_OUT = 16;
    localparam int MAX_CW  = 16;

    // a + b clamped to 2**cnt_w - 1.
    function automatic logic [MAX_CW-1:0] sat_add(input logic [MAX_CW-1:0] a,
                                                  input logic [MAX_CW-1:0] b,
                                                  input int              cnt_w);
        logic [MAX_CW:0] sum;
        logic [MAX_CW:0] lim;
        lim = (MAX_CW+1)'((33'd1 << cnt_w) - 33'd1);
        sum = {1'b0, a} + {1'b0, b};
        return (sum > lim) ? lim[MAX_CW-1:0] : sum[MAX_CW-1:0];
    endfunction

    // Index of the largest of the first n_out slots; strict compare keeps the lowest index on ties.
    function automatic int argmax(input logic [MAX_OUT*MAX_CW-1:0] counts,
                                  input int                        n_out);
        int              best;
        logic [MAX_CW-1:0] best_val;
        best     = 0;
        best_val = counts[MAX_CW-1:0];
        for (int i = 1; i < MAX_OUT; i++) begin
            if (i < n_out && counts[i*MAX_CW +: MAX_CW] > best_val) begin
                best     = i;
                best_val = counts[i*MAX_CW +: MAX_CW];
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/snn_infer_ctrl_if.sv
// rtl/snn_infer_ctrl_if.sv - input stream, network and result handshakes of the inference controller
interface snn_infer_ctrl_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2,
    parameter int CNT_W = 5,
    parameter int CLS_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
);
    logic                   s_valid;
    logic                   s_ready;
    logic [N_IN-1:0]        s_spikes;

    logic                   net_start;
    logic                   net_sample_ready;
    logic [N_IN-1:0]        net_in_spikes;
    logic                   net_sample;
    logic                   net_ready;
    logic [N_OUT-1:0]       net_out_spikes;

    logic                   res_valid;
    logic                   res_ready;
    logic [CLS_W-1:0]       res_class;
    logic [N_OUT*CNT_W-1:0] res_counts;
    logic                   res_underrun;

    // Controller side.
    modport master (
        input  s_valid, s_spikes, net_sample, net_ready, net_out_spikes, res_ready,
        output s_ready, net_start, net_sample_ready, net_in_spikes,
               res_valid, res_class, res_counts, res_underrun
    );

    // Environment side: vector source, network and result sink.
    modport slave (
        output s_valid, s_spikes, net_sample, net_ready, net_out_spikes, res_ready,
        input  s_ready, net_start, net_sample_ready, net_in_spikes,
               res_valid, res_class, res_counts, res_underrun
    );
endinterface

// File: rtl/snn_infer_ctrl_spike_fifo.sv
// rtl/snn_infer_ctrl_spike_fifo.sv - synchronous FIFO buffering per-timestep input spike vectors
module spike_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update; push and pop are independent so a simultaneous pair keeps occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/snn_infer_ctrl.sv
// rtl/snn_infer_ctrl.sv - sequences a spiking network through inferences and reports the argmax class
module snn_infer_ctrl
    import snn_ctrl_pkg::*;
#(
    parameter int N_IN       = 4,
    parameter int N_OUT      = 2,
    parameter int N_CYCLES   = 10,
    parameter int CNT_W      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_start,
    output logic                    busy,
    snn_infer_ctrl_if.master        bus
);
    localparam int CLS_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    state_t                  state;
    state_t                  state_nxt;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic [N_IN-1:0]         fifo_head;
    logic [CNT_W-1:0]        step_cnt;
    logic [CNT_W-1:0]        counts [N_OUT];
    logic                    underrun;
    logic                    sample_run;
    logic                    last_step;
    logic [MAX_OUT*MAX_CW-1:0] counts_wide;
    logic [N_OUT*CNT_W-1:0]  counts_flat;

    assign sample_run = (state == RUN) && bus.net_sample;
    assign last_step  = (step_cnt == CNT_W'(N_CYCLES - 1));
    assign fifo_push  = bus.s_valid && !fifo_full;
    assign fifo_pop   = sample_run && !fifo_empty;

    spike_fifo #(
        .WIDTH (N_IN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (bus.s_spikes),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // The FIFO accepts vectors in every state so the next frame can be preloaded.
    assign bus.s_ready          = !fifo_full;
    assign bus.net_sample_ready = (state == RUN) && !fifo_empty;
    assign bus.net_in_spikes    = fifo_empty ? '0 : fifo_head;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; cmd_start is only honoured in IDLE with the network idle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (cmd_start && bus.net_ready) state_nxt = START;
            START:    state_nxt = RUN;
            RUN:      if (bus.net_sample && last_step) state_nxt = WAIT_NET;
            WAIT_NET: if (bus.net_ready) state_nxt = ARGMAX;
            ARGMAX:   state_nxt = RESULT;
            RESULT:   if (bus.res_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy          = (state != IDLE);
        bus.net_start = (state == START);
        bus.res_valid = (state == RESULT);
    end

    // Per-timestep accumulation: step counter, saturating spike counts and underrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
            underrun <= 1'b0;
            for (int i = 0; i < N_OUT; i++) counts[i] <= '0;
        end else if (state == START) begin
            step_cnt <= '0;
            underrun <= 1'b0;
            for (int i = 0; i < N_OUT; i++) counts[i] <= '0;
        end else if (sample_run) begin
            step_cnt <= step_cnt + CNT_W'(1);
            if (fifo_empty) underrun <= 1'b1;
            for (int i = 0; i < N_OUT; i++) begin
                counts[i] <= CNT_W'(sat_add(MAX_CW'(counts[i]),
                                            MAX_CW'(bus.net_out_spikes[i]), CNT_W));
            end
        end
    end

    // Repack counts: zero-extended slots for argmax and the packed result layout.
    always_comb begin
        counts_wide = '0;
        counts_flat = '0;
        for (int i = 0; i < N_OUT; i++) begin
            counts_wide[i*MAX_CW +: MAX_CW] = MAX_CW'(counts[i]);
            counts_flat[i*CNT_W +: CNT_W]   = counts[i];
        end
    end

    // Result registers load only in ARGMAX and hold across the handshake until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.res_class    <= '0;
            bus.res_counts   <= '0;
            bus.res_underrun <= 1'b0;
        end else if (state == ARGMAX) begin
            bus.res_class    <= CLS_W'(argmax(counts_wide, N_OUT));
            bus.res_counts   <= counts_flat;
            bus.res_underrun <= underrun;
        end
    end
endmodule
